// File: rtl/sound_pkg.sv
// Shared types and the note table for the event-driven sound sequencer.
package sound_pkg;

  typedef enum logic {OFF = 1'b0, ON = 1'b1} MODE_TYPES;

  typedef enum logic [1:0] {
    SND_NONE = 2'd0,
    SND_TURN = 2'd1,
    SND_GOOD = 2'd2,
    SND_BAD  = 2'd3
  } sound_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [7:0] TURN_F0 = 8'd20;
  localparam logic [7:0] GOOD_F0 = 8'd40;
  localparam logic [7:0] GOOD_F1 = 8'd30;
  localparam logic [7:0] BAD_F0  = 8'd60;
  localparam logic [7:0] BAD_F1  = 8'd80;
  localparam logic [7:0] BAD_F2  = 8'd100;

  function automatic logic [1:0] note_count(input sound_e snd);
    case (snd)
      SND_TURN: note_count = 2'd1;
      SND_GOOD: note_count = 2'd2;
      SND_BAD:  note_count = 2'd3;
      default:  note_count = 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] note_freq(input sound_e snd, input logic [1:0] idx);
    note_freq = 8'd0;
    case (snd)
      SND_TURN: note_freq = TURN_F0;
      SND_GOOD: note_freq = (idx == 2'd0) ? GOOD_F0 : GOOD_F1;
      SND_BAD: begin
        case (idx)
          2'd0:    note_freq = BAD_F0;
          2'd1:    note_freq = BAD_F1;
          default: note_freq = BAD_F2;
        endcase
      end
      default: note_freq = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/sound_event_detector.sv
// Registered edge detection for the collision and button levels plus direction-change detection.
module sound_event_detector
(
  input  logic       clk,
  input  logic       rst,
  input  logic       good_i,
  input  logic       bad_i,
  input  logic       button_i,
  input  logic [3:0] direction_i,
  output logic       good_ev_o,
  output logic       bad_ev_o,
  output logic       button_ev_o,
  output logic       turn_ev_o
);

  logic       good_prev_q, bad_prev_q, button_prev_q;
  logic       good_prev_d, bad_prev_d, button_prev_d;
  logic [3:0] dir_prev_q, dir_prev_d;

  always_comb begin
    good_prev_d   = good_i;
    bad_prev_d    = bad_i;
    button_prev_d = button_i;
    dir_prev_d    = direction_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_prev_q   <= 1'b0;
      bad_prev_q    <= 1'b0;
      button_prev_q <= 1'b0;
      dir_prev_q    <= 4'b0000;
    end else begin
      good_prev_q   <= good_prev_d;
      bad_prev_q    <= bad_prev_d;
      button_prev_q <= button_prev_d;
      dir_prev_q    <= dir_prev_d;
    end
  end

  // Events are combinational so a flag can latch them on the very edge that first samples the input.
  assign good_ev_o   = good_i & ~good_prev_q;
  assign bad_ev_o    = bad_i & ~bad_prev_q;
  assign button_ev_o = button_i & ~button_prev_q;
  assign turn_ev_o   = (direction_i != 4'b0000) && (direction_i != dir_prev_q);

endmodule

// File: rtl/sound_sequencer.sv
// Arbitrates game sound events by priority and plays each as a timed sequence of notes.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter logic [15:0] NOTE_LEN = 16'd50000,
  parameter logic [15:0] GAP_LEN  = 16'd10000
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic       button_i,
  input  logic [3:0] direction_i,
  output logic [7:0] freq_o,
  output logic       play_o,
  output logic [1:0] sound_o,
  output logic       mode_o
);

  localparam logic [15:0] NOTE_LAST = NOTE_LEN - 16'd1;
  localparam logic [15:0] GAP_LAST  = GAP_LEN - 16'd1;

  logic good_ev_s, bad_ev_s, button_ev_s, turn_ev_s;

  sound_event_detector u_events (
    .clk         (clk),
    .rst         (rst),
    .good_i      (goodColl_i),
    .bad_i       (badColl_i),
    .button_i    (button_i),
    .direction_i (direction_i),
    .good_ev_o   (good_ev_s),
    .bad_ev_o    (bad_ev_s),
    .button_ev_o (button_ev_s),
    .turn_ev_o   (turn_ev_s)
  );

  state_e      state_q, state_d;
  sound_e      snd_q, snd_d, pick_s;
  MODE_TYPES   mode_q, mode_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d, next_idx_s;
  logic        pend_bad_q, pend_good_q, pend_turn_q;
  logic        pend_bad_d, pend_good_d, pend_turn_d;
  logic [7:0]  freq_q, freq_d;
  logic        play_q, play_d;
  logic        start_s, mute_s, accept_s;

  always_comb begin
    state_d    = state_q;
    snd_d      = snd_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    next_idx_s = idx_q + 2'd1;
    accept_s   = (mode_q == ON);
    mute_s     = button_ev_s && (mode_q == ON);
    mode_d     = button_ev_s ? ((mode_q == ON) ? OFF : ON) : mode_q;

    if (pend_bad_q)       pick_s = SND_BAD;
    else if (pend_good_q) pick_s = SND_GOOD;
    else if (pend_turn_q) pick_s = SND_TURN;
    else                  pick_s = SND_NONE;

    // A pending BAD cuts into any lesser sound; it never restarts itself.
    start_s = ((state_q == ST_IDLE) && (pick_s != SND_NONE)) ||
              ((state_q != ST_IDLE) && pend_bad_q && (snd_q != SND_BAD));

    pend_bad_d  = !mute_s && ((pend_bad_q  && !(start_s && pick_s == SND_BAD))  || (accept_s && bad_ev_s));
    pend_good_d = !mute_s && ((pend_good_q && !(start_s && pick_s == SND_GOOD)) || (accept_s && good_ev_s));
    pend_turn_d = !mute_s && ((pend_turn_q && !(start_s && pick_s == SND_TURN)) || (accept_s && turn_ev_s));

    if (mute_s) begin
      state_d = ST_IDLE;
      snd_d   = SND_NONE;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
    end else if (start_s) begin
      state_d = ST_PLAY;
      snd_d   = pick_s;
      idx_d   = 2'd0;
      cnt_d   = NOTE_LAST;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_PLAY, ST_GAP: begin
          if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
          end else if (state_q == ST_PLAY) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end else if (next_idx_s < note_count(snd_q)) begin
            state_d = ST_PLAY;
            idx_d   = next_idx_s;
            cnt_d   = NOTE_LAST;
          end else begin
            state_d = ST_IDLE;
            snd_d   = SND_NONE;
            idx_d   = 2'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          snd_d   = SND_NONE;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
        end
      endcase
    end

    play_d = (state_d == ST_PLAY);
    freq_d = play_d ? note_freq(snd_d, idx_d) : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      snd_q       <= SND_NONE;
      mode_q      <= ON;
      cnt_q       <= 16'd0;
      idx_q       <= 2'd0;
      pend_bad_q  <= 1'b0;
      pend_good_q <= 1'b0;
      pend_turn_q <= 1'b0;
      freq_q      <= 8'd0;
      play_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snd_q       <= snd_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_bad_q  <= pend_bad_d;
      pend_good_q <= pend_good_d;
      pend_turn_q <= pend_turn_d;
      freq_q      <= freq_d;
      play_q      <= play_d;
    end
  end

  assign freq_o  = freq_q;
  assign play_o  = play_q;
  assign sound_o = snd_q;
  assign mode_o  = mode_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench: a time-based reference model predicts every cycle's outputs, a monitor compares.
module tb_sound_sequencer;

  localparam int N = 4;
  localparam int G = 2;
  localparam int P = N + G;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       good = 1'b0, bad = 1'b0, btn = 1'b0;
  logic [3:0] dir = 4'b0000;
  logic [7:0] freq;
  logic       play;
  logic [1:0] sound;
  logic       mode;

  sound_sequencer #(.NOTE_LEN(16'd4), .GAP_LEN(16'd2)) dut (
    .clk         (clk),
    .rst         (rst),
    .goodColl_i  (good),
    .badColl_i   (bad),
    .button_i    (btn),
    .direction_i (dir),
    .freq_o      (freq),
    .play_o      (play),
    .sound_o     (sound),
    .mode_o      (mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] freq;
    logic       play;
    logic [1:0] sound;
    logic       mode;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: sound progress is a cycle count since the sound started.
  bit         mp_good, mp_bad, mp_btn;
  logic [3:0] mp_dir;
  bit         m_pb, m_pg, m_pt, m_mode, m_act;
  int         m_snd, m_t;

  function automatic int seq_len(input int s);
    return (s == 1) ? 1 : (s == 2) ? 2 : (s == 3) ? 3 : 0;
  endfunction

  function automatic logic [7:0] seq_freq(input int s, input int n);
    if (s == 1) return 8'd20;
    if (s == 2) return (n == 0) ? 8'd40 : 8'd30;
    if (s == 3) return (n == 0) ? 8'd60 : (n == 1) ? 8'd80 : 8'd100;
    return 8'd0;
  endfunction

  task automatic model_reset();
    mp_good = 1'b0; mp_bad = 1'b0; mp_btn = 1'b0; mp_dir = 4'b0000;
    m_pb = 1'b0; m_pg = 1'b0; m_pt = 1'b0; m_mode = 1'b1; m_act = 1'b0;
    m_snd = 0; m_t = 0;
  endtask

  task automatic model_step(input bit g, input bit b, input bit bt, input logic [3:0] d, input bit r);
    bit ge, be, bte, te;
    int start;
    obs_t e;
    if (r) begin
      model_reset();
    end else begin
      ge  = g && !mp_good;
      be  = b && !mp_bad;
      bte = bt && !mp_btn;
      te  = (d != 4'b0000) && (d != mp_dir);
      mp_good = g; mp_bad = b; mp_btn = bt; mp_dir = d;
      if (bte && m_mode) begin
        m_mode = 1'b0; m_pb = 1'b0; m_pg = 1'b0; m_pt = 1'b0; m_act = 1'b0; m_snd = 0;
      end else begin
        start = 0;
        if (!m_act && (m_pb || m_pg || m_pt)) start = m_pb ? 3 : m_pg ? 2 : 1;
        else if (m_act && m_snd != 3 && m_pb) start = 3;
        else if (m_act) begin
          m_t = m_t + 1;
          if (m_t == seq_len(m_snd) * P) begin
            m_act = 1'b0; m_snd = 0;
          end
        end
        if (start != 0) begin
          if (start == 3) m_pb = 1'b0;
          if (start == 2) m_pg = 1'b0;
          if (start == 1) m_pt = 1'b0;
          m_act = 1'b1; m_snd = start; m_t = 0;
        end
        if (m_mode) begin
          if (be) m_pb = 1'b1;
          if (ge) m_pg = 1'b1;
          if (te) m_pt = 1'b1;
        end
        if (bte) m_mode = 1'b1;
      end
    end
    e.play  = m_act && ((m_t % P) < N);
    e.freq  = e.play ? seq_freq(m_snd, m_t / P) : 8'd0;
    e.sound = m_act ? m_snd[1:0] : 2'd0;
    e.mode  = m_mode;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit g, input bit b, input bit bt, input logic [3:0] d, input bit r);
    @(negedge clk);
    good = g; bad = b; btn = bt; dir = d; rst = r;
    model_step(g, b, bt, d, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, dir, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest prediction after every clock edge.
  initial begin
    obs_t w, got;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        w   = exp_q.pop_front();
        got = '{freq: freq, play: play, sound: sound, mode: mode};
        n_cmp++;
        if (got !== w) begin
          n_err++;
          $display("FAIL scoreboard: got freq=%0d play=%0d snd=%0d mode=%0d want freq=%0d play=%0d snd=%0d mode=%0d at %0t",
                   got.freq, got.play, got.sound, got.mode, w.freq, w.play, w.sound, w.mode, $time);
        end
      end
    end
  end

  logic [7:0] good_tbl [13];

  initial begin
    bit rg, rb, rbt, rr;
    logic [3:0] rd;
    good_tbl = '{8'd40, 8'd40, 8'd40, 8'd40, 8'd0, 8'd0, 8'd30, 8'd30, 8'd30, 8'd30, 8'd0, 8'd0, 8'd0};
    model_reset();

    #1 rst = 1'b1;
    #1;
    chk("rst_freq", {24'd0, freq}, 32'd0);
    chk("rst_play", {31'd0, play}, 32'd0);
    chk("rst_sound", {30'd0, sound}, 32'd0);
    chk("rst_mode", {31'd0, mode}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    idle(2);

    // Good sequence with exact per-edge expectations
    cycle(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      @(posedge clk); #2;
      chk("good_freq", {24'd0, freq}, {24'd0, good_tbl[i]});
      chk("good_play", {31'd0, play}, {31'd0, (good_tbl[i] != 8'd0)});
    end
    chk("good_end_sound", {30'd0, sound}, 32'd0);
    idle(3);

    // Priority: BAD and GOOD on the same edge
    cycle(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    idle(40);

    // Preempt: turn, then BAD two cycles into the TURN note
    cycle(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    @(posedge clk); #2;
    chk("preempt_freq", {24'd0, freq}, 32'd60);
    chk("preempt_sound", {30'd0, sound}, 32'd3);
    idle(30);

    // Collapse: three GOOD pulses during a GOOD sequence
    cycle(1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
      idle(1);
    end
    idle(40);

    // Mute mid-note, BAD while OFF, then back ON
    cycle(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
    @(posedge clk); #2;
    chk("mute_mode", {31'd0, mode}, 32'd0);
    chk("mute_play", {31'd0, play}, 32'd0);
    chk("mute_freq", {24'd0, freq}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
    idle(20);
    chk("unmute_silent", {31'd0, play}, 32'd0);

    // Reset during BAD note 1
    cycle(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    idle(9);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001, 1'b1);
    #1;
    chk("midrst_freq", {24'd0, freq}, 32'd0);
    chk("midrst_play", {31'd0, play}, 32'd0);
    chk("midrst_sound", {30'd0, sound}, 32'd0);
    chk("midrst_mode", {31'd0, mode}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 4'b0001, 1'b1);
    idle(3);

    // Random traffic
    rg = 1'b0; rb = 1'b0; rbt = 1'b0; rd = 4'b0001;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) rg = ~rg;
      if ($urandom_range(0, 39) == 0) rb = ~rb;
      if ($urandom_range(0, 199) == 0) rbt = ~rbt;
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 4))
          0:       rd = 4'b0000;
          1:       rd = 4'b0001;
          2:       rd = 4'b0010;
          3:       rd = 4'b0100;
          default: rd = 4'b1000;
        endcase
      end
      rr = ($urandom_range(0, 999) == 0);
      cycle(rg, rb, rbt, rd, rr);
    end
    idle(30);
    @(posedge clk); #3;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Event-driven sound controller that sits between the game logic (collision flags, direction input, mute button) and the tone datapath (oscillator + DAC counter). It detects game events, arbitrates between them by fixed priority, and plays each event as a short sequence of notes. For each note it presents a frequency code and a play enable to the oscillator. A mute mode toggled by the button suppresses all sound.

## Interface
- NOTE_LEN, default 16'd50000: cycles each note is sounded (≥2).
- GAP_LEN, default 16'd10000: silent cycles after every note (≥1).
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- goodColl_i  in  1  good-collision level; a rising edge is one event
- badColl_i  in  1  bad-collision level; a rising edge is one event
- button_i  in  1  mute button level; a rising edge toggles mode
- direction_i  in  4  one-hot direction
- freq_o  out  8  note frequency code to the oscillator; 0 when silent
- play_o  out  1  oscillator enable
- sound_o  out  2  sound currently active (sound id enum)
- mode_o  out  1  MODE_TYPES: ON = sounding allowed

## Operation
- Edge detect: each level input is registered (prev reset 0). Event = input high and prev low. Turn event = direction_i nonzero and different from the registered previous direction (prev reset 4'b0000). The first nonzero direction after reset counts as a turn.
- Pending flags pend_bad, pend_good, pend_turn:
  - An event sets its flag while mode is ON. The flag is cleared when that sound starts.
  - Repeated events while pending collapse into one.
  - Events are discarded while mode is OFF.
- Sequences (freq codes):
  - TURN = {20}
  - GOOD = {40, 30}
  - BAD = {60, 80, 100}
- FSM states IDLE, PLAY, GAP. A note index and a 16-bit down-counter are tracked.
  - IDLE: if any flag is set, pick BAD > GOOD > TURN. Go to PLAY at note 0, load counter with NOTE_LEN-1, clear the chosen flag.
  - PLAY: play_o=1 and freq_o=table value. When counter=0, go to GAP and load GAP_LEN-1.
  - GAP: play_o=0 and freq_o=0. When counter=0:
    - if more notes remain, go to PLAY at the next note;
    - otherwise go to IDLE and set sound_o=NONE.
- Preemption: if pend_bad is set while a TURN or GOOD sound is in PLAY or GAP, abort it next cycle and start BAD note 0 directly in PLAY. The aborted sound is not resumed. BAD never preempts BAD; a second BAD event is queued.
- Mute: a button event flips mode_o. ON→OFF clears all flags and forces IDLE (freq_o=0, play_o=0, sound_o=NONE) at the same edge. OFF→ON accepts new events from the next cycle.
- Simultaneous button event and collision event on the same edge: the toggle takes effect, and the collision is judged against the mode before the toggle.

## Timing
- Reset values: freq_o=0, play_o=0, sound_o=NONE, mode_o=ON, FSM=IDLE, flags=0, counters=0.
- Reset mid-sequence returns everything to the reset values asynchronously.
- Latency: an input first sampled high at edge k sets the flag at edge k. PLAY starts at edge k+1, so play_o=1 after edge k+1.
- play_o is high for exactly NOTE_LEN cycles per note. Each gap is exactly GAP_LEN cycles, including the gap after the last note.
- Outputs are registered and there are no combinational paths from input to output.
- Preemption: BAD note 0 begins one edge after pend_bad is set. Its note duration is full NOTE_LEN.

## Structure
- Package sound_pkg holds:
  - MODE_TYPES (moved out of file scope);
  - sound id enum {SND_NONE, SND_TURN, SND_GOOD, SND_BAD};
  - FSM state enum;
  - note-table localparams.
- Sub-module sound_event_detector covers the registered edge detection and direction-change logic for all four inputs, with single-cycle event outputs.
- The top-level module sound_generator instantiates sound_sequencer in place of its own edge detector. The oscillator takes freq_o and play_o.

## Test plan
All tests use NOTE_LEN=4, GAP_LEN=2.
- Good: goodColl_i rises and is sampled at edge 0. Required: freq 40 with play_o=1 after edges 1–4, silence at edges 5–6, freq 30 after edges 7–10, silence at edges 11–12, then IDLE with sound_o=NONE.
- Priority: badColl_i and goodColl_i rise on the same edge. Required: full BAD sequence 60/80/100 plays, then the GOOD sequence 40/30; no note is shortened.
- Preempt: turn event, then bad event 2 cycles into the TURN note. Required: freq switches to 60 one edge after the bad flag sets, and BAD plays in full. The turn sound is not replayed.
- Collapse: three goodColl_i pulses during a GOOD sequence. Required: exactly one extra GOOD sequence follows.
- Mute: button pressed mid-note. Required: play_o=0, freq_o=0 and mode_o=OFF at the next edge. A badColl_i pulse while OFF produces no sound after the mode returns to ON.
- Reset: rst asserted during BAD note 1. Required: all outputs return to reset values immediately, with mode_o=ON.
